// File: rtl/timer_mc_core.sv
// timer_mc_core: 64/32-bit timer with power-of-two prescaler, NUM_CMP compare channels,
// sticky W1C status, channel-0 auto-reload and debug halt. Define TIMER_OVF_INT_EN for the bit-31 overflow interrupt.
module timer_mc_core #(
    parameter int CNT_W   = 64,
    parameter int NUM_CMP = 4,
    parameter int ADDR_W  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [31:0]        wdata,
    input  logic [3:0]         pstrb,
    input  logic               wr_en,
    input  logic               rd_en,
    output logic [31:0]        rdata,
    output logic               pslverr,
    input  logic               dbg_mode,
    output logic               halt_ack,
    output logic [NUM_CMP-1:0] tim_int_vec,
    output logic               tim_int
);
    localparam logic [ADDR_W-1:0] A_TCR   = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_TDR0  = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_TDR1  = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_C0L   = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_C0H   = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] A_TIER  = ADDR_W'(32'h14);
    localparam logic [ADDR_W-1:0] A_TISR  = ADDR_W'(32'h18);
    localparam logic [ADDR_W-1:0] A_THCSR = ADDR_W'(32'h1C);
    localparam logic [31:0] CH_MASK = 32'((64'd1 << NUM_CMP) - 64'd1);
`ifdef TIMER_OVF_INT_EN
    localparam logic [31:0] OVF_BIT = 32'h8000_0000;
`else
    localparam logic [31:0] OVF_BIT = 32'h0000_0000;
`endif
    localparam logic [31:0] IRQ_MASK = CH_MASK | OVF_BIT;

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        return (old_v & ~lane_mask(strb)) | (new_v & lane_mask(strb));
    endfunction

    function automatic logic [ADDR_W-1:0] tcmp_addr(input int idx, input logic hi);
        return ADDR_W'(32'h40 + 32'(8 * idx) + (hi ? 32'h4 : 32'h0));
    endfunction

    logic               timer_en_q, timer_en_d, div_en_q, div_en_d, ar_en_q, ar_en_d;
    logic [3:0]         div_val_q, div_val_d;
    logic               en_prev_q, en_prev_d;
    logic [7:0]         presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cmp_q [NUM_CMP];
    logic [CNT_W-1:0]   cmp_d [NUM_CMP];
    logic [31:0]        tier_q, tier_d, tisr_q, tisr_d;
    logic               halt_req_q, halt_req_d, halt_ack_q, halt_ack_d;
    logic [NUM_CMP-1:0] tim_int_vec_q, tim_int_vec_d;
    logic               tim_int_q, tim_int_d;

    logic               wr_tcr, wr_tdr0, wr_tdr1, wr_tier, wr_tisr, wr_thcsr;
    logic [NUM_CMP-1:0] cmpl_hit, cmph_hit, match;
    logic [2:0]         tcr_lo_new;
    logic [3:0]         div_val_new;
    logic               tcr_err, run, tick, ovf_set;
    logic [7:0]         presc_top;
    logic [63:0]        cnt_ext, cmp_ext;
    logic [31:0]        w1c, set_vec, tcr_cur;

    assign tcr_cur = {20'd0, div_val_q, 5'd0, ar_en_q, div_en_q, timer_en_q};

    always_comb begin
        wr_tcr   = wr_en && (addr == A_TCR);
        wr_tdr0  = wr_en && (addr == A_TDR0);
        wr_tdr1  = wr_en && (addr == A_TDR1) && (CNT_W == 64);
        wr_tier  = wr_en && (addr == A_TIER);
        wr_tisr  = wr_en && (addr == A_TISR);
        wr_thcsr = wr_en && (addr == A_THCSR);
        for (int i = 0; i < NUM_CMP; i++) begin
            cmpl_hit[i] = wr_en && ((addr == tcmp_addr(i, 1'b0)) || (i == 0 && addr == A_C0L));
            cmph_hit[i] = wr_en && (CNT_W == 64) &&
                          ((addr == tcmp_addr(i, 1'b1)) || (i == 0 && addr == A_C0H));
        end

        // Divider settings are frozen while the timer runs; enable/auto-reload bits stay writable.
        tcr_lo_new  = pstrb[0] ? wdata[2:0] : {ar_en_q, div_en_q, timer_en_q};
        div_val_new = pstrb[1] ? wdata[11:8] : div_val_q;
        tcr_err     = (pstrb[1] && (wdata[11:8] > 4'd8)) ||
                      (timer_en_q && ((tcr_lo_new[1] != div_en_q) || (div_val_new != div_val_q)));
        pslverr     = wr_tcr && tcr_err;

        timer_en_d = timer_en_q;
        div_en_d   = div_en_q;
        ar_en_d    = ar_en_q;
        div_val_d  = div_val_q;
        if (wr_tcr && !tcr_err) begin
            timer_en_d = tcr_lo_new[0];
            div_en_d   = tcr_lo_new[1];
            ar_en_d    = tcr_lo_new[2];
            div_val_d  = div_val_new;
        end
        en_prev_d = timer_en_q;

        run       = timer_en_q && !halt_ack_q;
        presc_top = 8'((9'd1 << div_val_q) - 9'd1);
        tick      = div_en_q ? (run && (presc_q == presc_top)) : run;
        presc_d   = presc_q;
        if (!timer_en_q || !div_en_q) presc_d = 8'd0;
        else if (run)                 presc_d = tick ? 8'd0 : presc_q + 8'd1;

        cnt_ext = 64'(cnt_q);
        if (wr_tdr0) cnt_ext[31:0]  = merge(cnt_ext[31:0], wdata, pstrb);
        if (wr_tdr1) cnt_ext[63:32] = merge(cnt_ext[63:32], wdata, pstrb);
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        if (en_prev_q && !timer_en_q) begin
            cnt_d = '0;
        end else if (wr_tdr0 || wr_tdr1) begin
            cnt_d = CNT_W'(cnt_ext);
        end else if (tick) begin
            if (ar_en_q && (cnt_q == cmp_q[0])) begin
                cnt_d = '0;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                ovf_set = &cnt_q;
            end
        end

        cmp_ext = '0;
        for (int i = 0; i < NUM_CMP; i++) begin
            cmp_ext = 64'(cmp_q[i]);
            if (cmpl_hit[i]) cmp_ext[31:0]  = merge(cmp_ext[31:0], wdata, pstrb);
            if (cmph_hit[i]) cmp_ext[63:32] = merge(cmp_ext[63:32], wdata, pstrb);
            cmp_d[i] = CNT_W'(cmp_ext);
            match[i] = (cnt_q == cmp_q[i]);
        end

        tier_d = wr_tier ? (merge(tier_q, wdata, pstrb) & IRQ_MASK) : tier_q;
        // A new set always beats a same-cycle write-1-to-clear.
        w1c     = wr_tisr ? (wdata & lane_mask(pstrb) & IRQ_MASK) : 32'd0;
        set_vec = 32'(match) | (ovf_set ? OVF_BIT : 32'd0);
        tisr_d  = ((tisr_q & ~w1c) | set_vec) & IRQ_MASK;

        halt_req_d = (wr_thcsr && pstrb[0]) ? wdata[0] : halt_req_q;
        halt_ack_d = halt_req_q && dbg_mode;

        tim_int_vec_d = tisr_d[NUM_CMP-1:0] & tier_d[NUM_CMP-1:0];
        tim_int_d     = |(tisr_d & tier_d);
    end

    logic [63:0] cnt_rd, cmp_rd;
    logic [31:0] rd_val;

    always_comb begin
        rd_val = 32'd0;
        cnt_rd = 64'(cnt_q);
        cmp_rd = 64'(cmp_q[0]);
        if (addr == A_TCR)   rd_val = tcr_cur;
        if (addr == A_TDR0)  rd_val = cnt_rd[31:0];
        if (addr == A_TDR1)  rd_val = cnt_rd[63:32];
        if (addr == A_C0L)   rd_val = cmp_rd[31:0];
        if (addr == A_C0H)   rd_val = cmp_rd[63:32];
        if (addr == A_TIER)  rd_val = tier_q;
        if (addr == A_TISR)  rd_val = tisr_q;
        if (addr == A_THCSR) rd_val = {30'd0, halt_ack_q, halt_req_q};
        for (int i = 0; i < NUM_CMP; i++) begin
            cmp_rd = 64'(cmp_q[i]);
            if (addr == tcmp_addr(i, 1'b0)) rd_val = cmp_rd[31:0];
            if (addr == tcmp_addr(i, 1'b1)) rd_val = cmp_rd[63:32];
        end
        rdata = rd_en ? rd_val : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_en_q    <= 1'b0;
            div_en_q      <= 1'b0;
            ar_en_q       <= 1'b0;
            div_val_q     <= 4'd1;
            en_prev_q     <= 1'b0;
            presc_q       <= 8'd0;
            cnt_q         <= '0;
            for (int i = 0; i < NUM_CMP; i++) cmp_q[i] <= '1;
            tier_q        <= 32'd0;
            tisr_q        <= 32'd0;
            halt_req_q    <= 1'b0;
            halt_ack_q    <= 1'b0;
            tim_int_vec_q <= '0;
            tim_int_q     <= 1'b0;
        end else begin
            timer_en_q    <= timer_en_d;
            div_en_q      <= div_en_d;
            ar_en_q       <= ar_en_d;
            div_val_q     <= div_val_d;
            en_prev_q     <= en_prev_d;
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            for (int i = 0; i < NUM_CMP; i++) cmp_q[i] <= cmp_d[i];
            tier_q        <= tier_d;
            tisr_q        <= tisr_d;
            halt_req_q    <= halt_req_d;
            halt_ack_q    <= halt_ack_d;
            tim_int_vec_q <= tim_int_vec_d;
            tim_int_q     <= tim_int_d;
        end
    end

    assign halt_ack    = halt_ack_q;
    assign tim_int_vec = tim_int_vec_q;
    assign tim_int     = tim_int_q;
endmodule

// File: tb/tb_timer_mc_core.sv
// Self-checking bench for timer_mc_core (CNT_W=64, NUM_CMP=4): register table, directed timing
// sequences and a randomized run checked against a closed-form counter/status model.
module tb_timer_mc_core;
  localparam logic [11:0] TCR = 12'h000, TDR0 = 12'h004, TDR1 = 12'h008, C0L = 12'h00C,
                          C0H = 12'h010, TIER = 12'h014, TISR = 12'h018, THCSR = 12'h01C;

  logic        clk, rst, wr_en, rd_en, pslverr, dbg_mode, halt_ack, tim_int;
  logic [11:0] addr;
  logic [31:0] wdata, rdata, v;
  logic [3:0]  pstrb, tim_int_vec;
  logic        err;
  int          n_pass, n_total;

  timer_mc_core #(.CNT_W(64), .NUM_CMP(4), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .pstrb(pstrb), .wr_en(wr_en),
    .rd_en(rd_en), .rdata(rdata), .pslverr(pslverr), .dbg_mode(dbg_mode),
    .halt_ack(halt_ack), .tim_int_vec(tim_int_vec), .tim_int(tim_int)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic e);
    addr = a; wdata = d; pstrb = s; wr_en = 1'b1;
    #1 e = pslverr;
    @(negedge clk);
    wr_en = 1'b0; pstrb = 4'h0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic e;
    bus_wr(a, d, 4'hF, e);
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    #1 d = rdata;
    rd_en = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(name, d, exp);
  endtask

  // Counter value after k ticks, from the start value and the reload rule.
  function automatic longint unsigned model_cnt(input longint unsigned start,
      input longint unsigned cmp0, input bit ar, input longint unsigned k);
    if (ar) return (start + k) % (cmp0 + 1);
    return start + k;
  endfunction

  typedef struct packed {
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [11:0] raddr;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs [12];

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; pstrb = '0; wr_en = 1'b0; rd_en = 1'b0; dbg_mode = 1'b0;
    n_pass = 0; n_total = 0;
    vecs[0]  = '{TCR,    32'h0000_0900, 4'hF, TCR,    32'h0000_0100, 1'b1};
    vecs[1]  = '{TCR,    32'h0000_0800, 4'hF, TCR,    32'h0000_0800, 1'b0};
    vecs[2]  = '{TCR,    32'h0000_0306, 4'h1, TCR,    32'h0000_0806, 1'b0};
    vecs[3]  = '{TCR,    32'h0000_0F00, 4'h1, TCR,    32'h0000_0800, 1'b0};
    vecs[4]  = '{TCR,    32'h0000_0100, 4'h3, TCR,    32'h0000_0100, 1'b0};
`ifdef TIMER_OVF_INT_EN
    vecs[5]  = '{TIER,   32'hFFFF_FFFF, 4'hF, TIER,   32'h8000_000F, 1'b0};
`else
    vecs[5]  = '{TIER,   32'hFFFF_FFFF, 4'hF, TIER,   32'h0000_000F, 1'b0};
`endif
    vecs[6]  = '{TIER,   32'h0000_0000, 4'hF, TIER,   32'h0000_0000, 1'b0};
    vecs[7]  = '{C0L,    32'h1234_5678, 4'h5, 12'h040, 32'hFF34_FF78, 1'b0};
    vecs[8]  = '{12'h04C, 32'hA5A5_A5A5, 4'hF, 12'h04C, 32'hA5A5_A5A5, 1'b0};
    vecs[9]  = '{12'h020, 32'hDEAD_BEEF, 4'hF, 12'h020, 32'h0000_0000, 1'b0};
    vecs[10] = '{THCSR,  32'h0000_0002, 4'hF, THCSR,  32'h0000_0000, 1'b0};
    vecs[11] = '{TDR0,   32'h0000_00AB, 4'h1, TDR0,   32'h0000_00AB, 1'b0};

    idle(2);
    rst = 1'b0;

    // ---- reset state ----
    rd_chk("rst_tcr", TCR, 32'h100);
    rd_chk("rst_tdr0", TDR0, 32'h0);
    rd_chk("rst_tdr1", TDR1, 32'h0);
    rd_chk("rst_c0l_alias", C0L, 32'hFFFF_FFFF);
    rd_chk("rst_c0h_alias", C0H, 32'hFFFF_FFFF);
    rd_chk("rst_tier", TIER, 32'h0);
    rd_chk("rst_tisr", TISR, 32'h0);
    rd_chk("rst_thcsr", THCSR, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd_chk($sformatf("rst_tcmpl%0d", i), 12'(12'h040 + 8 * i), 32'hFFFF_FFFF);
      rd_chk($sformatf("rst_tcmph%0d", i), 12'(12'h044 + 8 * i), 32'hFFFF_FFFF);
    end
    rd_chk("rst_unmapped", 12'h020, 32'h0);
    check("rst_tim_int", tim_int, 1'b0);
    check("rst_tim_int_vec", tim_int_vec, 4'h0);
    check("rst_halt_ack", halt_ack, 1'b0);
    addr = TCR; #1 check("rdata_idle_zero", rdata, 32'h0);

    // ---- register table ----
    for (int i = 0; i < 12; i++) begin
      bus_wr(vecs[i].waddr, vecs[i].wdata, vecs[i].strb, err);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      rd_chk($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
    end
    do_reset();

    // ---- compare channel 2 interrupt and W1C ----
    begin
      bit found;
      wr(12'h050, 32'd5);
      wr(12'h054, 32'd0);
      wr(TIER, 32'h4);
      bus_wr(TCR, 32'h1, 4'hF, err);
      check("a_tcr_err", err, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        bus_rd(TDR0, v);
        if (v == 32'd5) found = 1'b1;
        else idle(1);
      end
      check("a_reach5", found, 1'b1);
      rd_chk("a_tisr_before", TISR, 32'h0);
      check("a_int_before", tim_int, 1'b0);
      idle(1);
      rd_chk("a_tisr_set", TISR, 32'h4);
      check("a_int_set", tim_int, 1'b1);
      check("a_vec_set", tim_int_vec, 4'h4);
      wr(TISR, 32'h4);
      rd_chk("a_tisr_clr", TISR, 32'h0);
      check("a_int_clr", tim_int, 1'b0);
      bus_wr(TCR, 32'h0, 4'hF, err);
      check("a_stop_err", err, 1'b0);
      idle(2);
      rd_chk("a_cnt_cleared", TDR0, 32'h0);
    end

    // ---- prescaler /8 and locked divider ----
    bus_wr(TCR, 32'h303, 4'hF, err);
    check("b_tcr_err", err, 1'b0);
    idle(7); rd_chk("b_cnt_7", TDR0, 32'd0);
    idle(1); rd_chk("b_cnt_8", TDR0, 32'd1);
    idle(8); rd_chk("b_cnt_16", TDR0, 32'd2);
    bus_wr(TCR, 32'h403, 4'hF, err);
    check("b_divval_locked_err", err, 1'b1);
    rd_chk("b_tcr_kept", TCR, 32'h303);
    bus_wr(TCR, 32'h301, 4'hF, err);
    check("b_diven_locked_err", err, 1'b1);
    bus_wr(TCR, 32'h302, 4'hF, err);
    check("b_stop_err", err, 1'b0);
    rd_chk("b_tcr_stopped", TCR, 32'h302);
    idle(2);

    // ---- auto-reload on channel 0 ----
    wr(12'h040, 32'd3);
    wr(12'h044, 32'd0);
    wr(TISR, 32'hFFFF_FFFF);
    bus_wr(TCR, 32'h5, 4'hF, err);
    check("c_tcr_err", err, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      rd_chk($sformatf("c_seq%0d", k), TDR0, 32'(k % 4));
    end
    wr(TISR, 32'h1);
    rd_chk("c_tisr_clr", TISR, 32'h0);
    idle(3);
    rd_chk("c_tisr_rewrap", TISR, 32'h1);
    wr(TDR0, 32'h10);
    rd_chk("c_tdr_wins", TDR0, 32'h10);
    idle(1);
    rd_chk("c_after_tdr", TDR0, 32'h11);
    bus_wr(TCR, 32'h1, 4'hF, err);
    check("c_ar_only_err", err, 1'b0);
    bus_wr(TCR, 32'h0, 4'hF, err);
    check("c_stop_err", err, 1'b0);
    idle(2);

    // ---- debug halt ----
    do_reset();
    bus_wr(TCR, 32'h1, 4'hF, err);
    idle(2);
    dbg_mode = 1'b1;
    wr(THCSR, 32'h1);
    check("d_ack_lat0", halt_ack, 1'b0);
    rd_chk("d_cnt3", TDR0, 32'd3);
    idle(1);
    check("d_ack_set", halt_ack, 1'b1);
    rd_chk("d_cnt4", TDR0, 32'd4);
    idle(3);
    rd_chk("d_cnt_held", TDR0, 32'd4);
    rd_chk("d_thcsr", THCSR, 32'h3);
    dbg_mode = 1'b0;
    idle(1);
    check("d_ack_clr", halt_ack, 1'b0);
    rd_chk("d_cnt_still4", TDR0, 32'd4);
    idle(1);
    rd_chk("d_cnt_resume", TDR0, 32'd5);

    // ---- overflow flag ----
    do_reset();
`ifdef TIMER_OVF_INT_EN
    wr(TDR0, 32'hFFFF_FFFF);
    wr(TDR1, 32'hFFFF_FFFF);
    wr(TIER, 32'h8000_0000);
    wr(TISR, 32'hFFFF_FFFF);
    wr(TCR, 32'h1);
    idle(1);
    bus_rd(TISR, v);
    check("e_ovf_flag", v & 32'h8000_0000, 32'h8000_0000);
    check("e_ovf_int", tim_int, 1'b1);
    check("e_ovf_vec", tim_int_vec, 4'h0);
    rd_chk("e_wrap_hi", TDR1, 32'h0);
    wr(TISR, 32'h8000_0000);
    bus_rd(TISR, v);
    check("e_ovf_clr", v & 32'h8000_0000, 32'h0);
    check("e_ovf_int_clr", tim_int, 1'b0);
`else
    wr(TIER, 32'h8000_000F);
    rd_chk("e_tier_bit31_ro", TIER, 32'hF);
    wr(TISR, 32'h8000_0000);
    rd_chk("e_tisr_bit31_zero", TISR, 32'h0);
`endif
    do_reset();

    // ---- randomized runs against the closed-form model ----
    for (int it = 0; it < 30; it++) begin
      bit div_en, ar;
      int d, n;
      longint unsigned start, cmpv[4], ticks, prev;
      logic [31:0] tier_v, exp_tisr, tcr_v;
      div_en = 1'($urandom_range(0, 1));
      ar     = 1'($urandom_range(0, 1));
      d      = $urandom_range(0, 3);
      n      = $urandom_range(1, 120);
      cmpv[0] = $urandom_range(3, 40);
      start   = ar ? $urandom_range(0, 32'(cmpv[0])) : $urandom_range(0, 20);
      for (int i = 1; i < 4; i++) cmpv[i] = $urandom_range(0, 60);
      tier_v = $urandom_range(0, 15);
      wr(TDR0, 32'(start));
      wr(TDR1, 32'h0);
      for (int i = 0; i < 4; i++) begin
        wr(12'(12'h040 + 8 * i), 32'(cmpv[i]));
        wr(12'(12'h044 + 8 * i), 32'h0);
      end
      wr(TIER, tier_v);
      wr(TISR, 32'hFFFF_FFFF);
      tcr_v = 32'h1 | (32'(div_en) << 1) | (32'(ar) << 2) | (32'(d) << 8);
      bus_wr(TCR, tcr_v, 4'hF, err);
      check($sformatf("r%0d_tcr_err", it), err, 1'b0);
      idle(n);
      ticks = div_en ? longint'(n >> d) : longint'(n);
      prev  = div_en ? longint'((n - 1) >> d) : longint'(n - 1);
      exp_tisr = 32'h0;
      for (int i = 0; i < 4; i++)
        for (longint unsigned k = 0; k <= prev; k++)
          if (model_cnt(start, cmpv[0], ar, k) == cmpv[i]) exp_tisr[i] = 1'b1;
      rd_chk($sformatf("r%0d_cnt", it), TDR0, 32'(model_cnt(start, cmpv[0], ar, ticks)));
      rd_chk($sformatf("r%0d_cnt_hi", it), TDR1, 32'h0);
      rd_chk($sformatf("r%0d_tisr", it), TISR, exp_tisr);
      check($sformatf("r%0d_vec", it), tim_int_vec, 4'(exp_tisr & tier_v));
      check($sformatf("r%0d_int", it), tim_int, |(exp_tisr & tier_v));
      bus_wr(TCR, tcr_v & ~32'h1, 4'hF, err);
      check($sformatf("r%0d_stop_err", it), err, 1'b0);
      idle(2);
    end

    // ---- reset in the middle of a running timer and a write ----
    wr(TCR, 32'h1);
    idle(5);
    rst = 1'b1;
    wr(TIER, 32'hF);
    rst = 1'b0;
    rd_chk("m_tcr", TCR, 32'h100);
    rd_chk("m_tier", TIER, 32'h0);
    rd_chk("m_tdr0", TDR0, 32'h0);
    rd_chk("m_c0l", C0L, 32'hFFFF_FFFF);
    check("m_tim_int", tim_int, 1'b0);
    check("m_halt_ack", halt_ack, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
